decode_issue: RTL and testbench

- Decode/issue stage of the fetch-decode-execute pipeline; transmitting end of the 181-bit ID_EX bus consumed by execute.
- Slices a 32-bit instruction word and reads operands from an internal 32x32 register file.
- Write port of the register file is driven by writeback.
- Scoreboard stalls issue on RAW/WAW hazards, since execute has no forwarding. Registered ID_EX output with valid/ready handshake.

---
 rtl/fde_pkg.sv | 48 ++++
 rtl/decode_regfile.sv | 40 ++++
 rtl/decode_issue.sv | 132 +++++++++++++
 tb/tb_decode_issue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
`default_nettype none
// fde_pkg: opcodes, ID_EX bus layout and opcode classification shared by decode and execute.
// Rev 1.0
package fde_pkg;

   localparam logic [3:0] OP_ILL = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_LDI = 4'h3;
   localparam logic [3:0] OP_SLL = 4'h4;
   localparam logic [3:0] OP_SRL = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_BR  = 4'h9;
   localparam logic [3:0] OP_BNE = 4'hA;
   localparam logic [3:0] OP_MOV = 4'hB;
   localparam logic [3:0] OP_ADI = 4'hC;
   localparam logic [3:0] OP_MUL = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hE;
   localparam logic [3:0] OP_NOP = 4'hF;

   localparam int ID_EX_W   = 181;
   localparam int IDX_PC    = 0;
   localparam int IDX_RSV   = 32;
   localparam int IDX_RTV   = 64;
   localparam int IDX_RD    = 96;
   localparam int IDX_IMM   = 112;
   localparam int IDX_OP    = 160;
   localparam int IDX_SHAMT = 176;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   function automatic logic is_writer(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_LDI, OP_SLL, OP_SRL, OP_AND, OP_OR,
                        OP_XOR, OP_MOV, OP_ADI, OP_MUL};
   endfunction

   function automatic logic is_reader(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR,
                        OP_BNE, OP_MOV, OP_ADI, OP_MUL};
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// decode_regfile: 2R/1W register file, R0 hard-wired to zero.
// Rev 1.0 -- DECODE_BYPASS_EN forwards same-cycle write data to matching reads.
module decode_regfile
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      i_rd_addr_a,
   output logic [XLEN-1:0] o_rd_data_a,
   input  logic [4:0]      i_rd_addr_b,
   output logic [XLEN-1:0] o_rd_data_b,
   input  logic            i_we,
   input  logic [4:0]      i_wr_addr,
   input  logic [XLEN-1:0] i_wr_data
);

   logic [XLEN-1:0] r_mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      end else if (i_we && i_wr_addr != 5'd0) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data_a = (i_rd_addr_a == 5'd0) ? '0 : r_mem[i_rd_addr_a];
      o_rd_data_b = (i_rd_addr_b == 5'd0) ? '0 : r_mem[i_rd_addr_b];
`ifdef DECODE_BYPASS_EN
      if (i_we && i_wr_addr != 5'd0 && i_rd_addr_a == i_wr_addr) o_rd_data_a = i_wr_data;
      if (i_we && i_wr_addr != 5'd0 && i_rd_addr_b == i_wr_addr) o_rd_data_b = i_wr_data;
`endif
   end

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// decode_issue: decode/issue stage, scoreboard RAW/WAW stall, registered ID_EX with valid/ready.
// Rev 1.0 -- option DECODE_BYPASS_EN: regfile write-through and same-edge scoreboard clear.
module decode_issue
   import fde_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instr,
   input  logic [31:0]        pc,
   output logic [ID_EX_W-1:0] ID_EX,
   output logic               id_valid,
   input  logic               id_ready,
   input  logic               wb_we,
   input  logic [4:0]         wb_addr,
   input  logic [XLEN-1:0]    wb_data,
   output logic               halted,
   output logic               illegal
);

   state_t             r_state, w_state_nxt;
   logic [NREGS-1:0]   r_sb, w_sb_set, w_sb_clr;
   logic [ID_EX_W-1:0] r_id_ex, w_id_ex;
   logic               r_id_valid, r_illegal;
   logic [3:0]         w_op;
   logic [4:0]         w_rd, w_rs, w_rt, w_shamt;
   logic [15:0]        w_imm;
   logic [XLEN-1:0]    w_rs_val, w_rt_val;
   logic               w_hazard, w_accept;

   assign w_op    = instr[31:28];
   assign w_rd    = instr[27:23];
   assign w_rs    = instr[22:18];
   assign w_rt    = instr[17:13];
   assign w_shamt = instr[12:8];
   assign w_imm   = instr[15:0];

   decode_regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN)
   ) u_regfile (
      .clk         (clock),
      .rst_n       (reset),
      .i_rd_addr_a (w_rs),
      .o_rd_data_a (w_rs_val),
      .i_rd_addr_b (w_rt),
      .o_rd_data_b (w_rt_val),
      .i_we        (wb_we),
      .i_wr_addr   (wb_addr),
      .i_wr_data   (wb_data)
   );

   assign w_hazard = (is_reader(w_op) && (r_sb[w_rs] || r_sb[w_rt])) ||
                     (is_writer(w_op) && r_sb[w_rd]);

   assign instr_ready = (r_state == ST_RUN) && (!r_id_valid || id_ready) && !w_hazard;
   assign w_accept    = instr_valid && instr_ready;

   assign w_sb_set = (w_accept && is_writer(w_op) && w_rd != 5'd0) ? (NREGS'(1) << w_rd) : '0;

`ifdef DECODE_BYPASS_EN
   assign w_sb_clr = (wb_we && wb_addr != 5'd0) ? (NREGS'(1) << wb_addr) : '0;
`else
   // Without write-through the clear trails the array write by one edge.
   logic       r_clr_vld;
   logic [4:0] r_clr_addr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_clr_vld  <= 1'b0;
         r_clr_addr <= 5'd0;
      end else begin
         r_clr_vld  <= wb_we && wb_addr != 5'd0;
         r_clr_addr <= wb_addr;
      end
   end

   assign w_sb_clr = r_clr_vld ? (NREGS'(1) << r_clr_addr) : '0;
`endif

   always_comb begin
      w_id_ex                     = '0;
      w_id_ex[IDX_PC +: 32]       = pc;
      w_id_ex[IDX_RSV +: 32]      = w_rs_val;
      w_id_ex[IDX_RTV +: 32]      = w_rt_val;
      w_id_ex[IDX_RD +: 5]        = w_rd;
      w_id_ex[IDX_IMM +: 16]      = w_imm;
      w_id_ex[IDX_OP +: 4]        = (w_op == OP_ILL) ? OP_NOP : w_op;
      w_id_ex[IDX_SHAMT +: 5]     = w_shamt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_RUN && w_accept && w_op == OP_HLT) w_state_nxt = ST_HALT;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_id_ex    <= '0;
         r_id_valid <= 1'b0;
         r_sb       <= '0;
         r_illegal  <= 1'b0;
      end else begin
         // Set is OR-ed in after the clear so a same-edge set wins.
         r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
         if (w_accept) begin
            r_id_ex    <= w_id_ex;
            r_id_valid <= 1'b1;
            if (w_op == OP_ILL) r_illegal <= 1'b1;
         end else if (id_ready) begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign ID_EX    = r_id_ex;
   assign id_valid = r_id_valid;
   assign halted   = (r_state == ST_HALT);
   assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// tb_decode_issue: directed self-checking bench for decode_issue.
// Rev 1.0
module tb_decode_issue;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [31:0]  instr = '0;
   logic [31:0]  pc = '0;
   logic [180:0] ID_EX;
   logic         id_valid;
   logic         id_ready = 1'b0;
   logic         wb_we = 1'b0;
   logic [4:0]   wb_addr = '0;
   logic [31:0]  wb_data = '0;
   logic         halted;
   logic         illegal;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DECODE_BYPASS_EN
   localparam int EXP_WAIT = 1;
`else
   localparam int EXP_WAIT = 2;
`endif

   decode_issue dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .pc          (pc),
      .ID_EX       (ID_EX),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .halted      (halted),
      .illegal     (illegal)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
      return {op, rd, rs, rt, 13'h0};
   endfunction

   function automatic logic [180:0] exp_idex(input logic [31:0] p, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ins);
      logic [3:0] op;
      op = (ins[31:28] == 4'h0) ? 4'hF : ins[31:28];
      return {ins[12:8], 12'h0, op, 32'h0, ins[15:0], 11'h0, ins[27:23], b, a, p};
   endfunction

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
      n_cmp++; if (ID_EX !== '0) begin n_bad++; $display("FAIL rst_id_ex: got %h want 0", ID_EX); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_instr_ready: got %b want 1", instr_ready); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_add();
      logic [31:0] ins;
      wb_write(5'd1, 32'd5);
      wb_write(5'd2, 32'd7);
      ins = mk(4'h1, 5'd3, 5'd1, 5'd2);
      instr = ins; pc = 32'h100; instr_valid = 1'b1; id_ready = 1'b1;
      #1;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL add_id_valid: got %b want 1", id_valid); end
      n_cmp++; if (ID_EX !== exp_idex(32'h100, 32'd5, 32'd7, ins)) begin n_bad++; $display("FAIL add_id_ex: got %h want %h", ID_EX, exp_idex(32'h100, 32'd5, 32'd7, ins)); end
      n_cmp++; if (ID_EX[175:160] !== 16'h0001) begin n_bad++; $display("FAIL add_op_field: got %h want 0001", ID_EX[175:160]); end
   endtask

   task automatic test_raw_hazard();
      logic [31:0] ins;
      int wait_n;
      ins = mk(4'h2, 5'd4, 5'd3, 5'd1);
      instr = ins; pc = 32'h104; instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall[%0d]: got %b want 0", i, instr_ready); end
         step();
      end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL raw_drain: got %b want 0", id_valid); end
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'd12;
      #1;
      n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL raw_wb_cycle: got %b want 0", instr_ready); end
      step();
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      wait_n = 1;
      #1;
      while (instr_ready !== 1'b1 && wait_n < 8) begin
         step(); wait_n++; #1;
      end
      n_cmp++; if (wait_n !== EXP_WAIT) begin n_bad++; $display("FAIL raw_release_cycles: got %0d want %0d", wait_n, EXP_WAIT); end
      step();
      instr_valid = 1'b0;
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL raw_issue_valid: got %b want 1", id_valid); end
      n_cmp++; if (ID_EX !== exp_idex(32'h104, 32'd12, 32'd5, ins)) begin n_bad++; $display("FAIL raw_issue_id_ex: got %h want %h", ID_EX, exp_idex(32'h104, 32'd12, 32'd5, ins)); end
      wb_write(5'd4, 32'h20);
      step(); step();
   endtask

   task automatic test_stall();
      logic [31:0]  ldi, nop;
      logic [180:0] e_ldi, e_nop;
      ldi = {4'h3, 5'd5, 7'd0, 16'h1234};
      nop = 32'hF000_0000;
      e_ldi = exp_idex(32'h200, 32'd0, 32'd0, ldi);
      e_nop = exp_idex(32'h204, 32'd0, 32'd0, nop);
      instr = ldi; pc = 32'h200; instr_valid = 1'b1; id_ready = 1'b0;
      step();
      n_cmp++; if (ID_EX !== e_ldi) begin n_bad++; $display("FAIL stall_ldi_id_ex: got %h want %h", ID_EX, e_ldi); end
      instr = nop; pc = 32'h204;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, instr_ready); end
         n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, id_valid); end
         n_cmp++; if (ID_EX !== e_ldi) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, ID_EX, e_ldi); end
         step();
      end
      id_ready = 1'b1;
      #1;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      n_cmp++; if (ID_EX !== e_nop) begin n_bad++; $display("FAIL stall_next_issue: got %h want %h", ID_EX, e_nop); end
      step();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid: got %b want 0", id_valid); end
      n_cmp++; if (ID_EX !== e_nop) begin n_bad++; $display("FAIL drain_hold: got %h want %h", ID_EX, e_nop); end
      wb_write(5'd5, 32'h1234);
      step(); step();
   endtask

   task automatic test_illegal();
      #1;
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL ill_pre: got %b want 0", illegal); end
      instr = 32'h0; pc = 32'h300; instr_valid = 1'b1;
      step();
      n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_set: got %b want 1", illegal); end
      n_cmp++; if (ID_EX[175:160] !== 16'h000F) begin n_bad++; $display("FAIL ill_op_nop: got %h want 000f", ID_EX[175:160]); end
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL ill_valid: got %b want 1", id_valid); end
      instr = mk(4'h1, 5'd0, 5'd0, 5'd0); pc = 32'h304;
      #1;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL ill_no_sb: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_sticky: got %b want 1", illegal); end
   endtask

   task automatic test_r0();
      wb_write(5'd0, 32'hFFFF_FFFF);
      instr = mk(4'h1, 5'd6, 5'd0, 5'd0); pc = 32'h400; instr_valid = 1'b1;
      step();
      n_cmp++; if (ID_EX[63:32] !== 32'h0) begin n_bad++; $display("FAIL r0_read_rs: got %h want 0", ID_EX[63:32]); end
      n_cmp++; if (ID_EX[95:64] !== 32'h0) begin n_bad++; $display("FAIL r0_read_rt: got %h want 0", ID_EX[95:64]); end
      instr = {4'h3, 5'd0, 7'd0, 16'hBEEF}; pc = 32'h404;
      step();
      instr = mk(4'h1, 5'd7, 5'd0, 5'd0); pc = 32'h408;
      #1;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ldi_no_stall: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      n_cmp++; if (ID_EX[31:0] !== 32'h408) begin n_bad++; $display("FAIL r0_back_to_back_pc: got %h want 408", ID_EX[31:0]); end
   endtask

   task automatic test_halt();
      instr = 32'hE000_0000; pc = 32'h500; instr_valid = 1'b1;
      step();
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL hlt_halted: got %b want 1", halted); end
      n_cmp++; if (ID_EX[175:160] !== 16'h000E) begin n_bad++; $display("FAIL hlt_op: got %h want 000e", ID_EX[175:160]); end
      instr = mk(4'h1, 5'd8, 5'd1, 5'd2); pc = 32'h504;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL hlt_block[%0d]: got %b want 0", i, instr_ready); end
         step();
      end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL hlt_no_add: got %b want 0", id_valid); end
      n_cmp++; if (ID_EX[31:0] !== 32'h500) begin n_bad++; $display("FAIL hlt_hold_pc: got %h want 500", ID_EX[31:0]); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL arst_halted: got %b want 0", halted); end
      n_cmp++; if (ID_EX !== '0) begin n_bad++; $display("FAIL arst_id_ex: got %h want 0", ID_EX); end
      n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL arst_illegal: got %b want 0", illegal); end
      @(negedge clock);
      reset = 1'b1;
      instr = mk(4'h2, 5'd9, 5'd6, 5'd7); pc = 32'h600;
      #1;
      n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL arst_sb_clear: got %b want 1", instr_ready); end
      instr_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_raw_hazard();
      test_stall();
      test_illegal();
      test_r0();
      test_halt();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
